// File: rtl/ram_cfg_pkg.sv
// ==========================================================================
// ram_cfg_pkg : shared types and reset-value helper for the partitioned RAM
// Revision    : 1.0
// ==========================================================================
`default_nettype none

package ram_cfg_pkg;

  localparam int RAM_RESET_ZERO = 0;
  localparam int RAM_RESET_SEQ  = 1;

  typedef enum logic [0:0] {
    RAM_INIT  = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  // Wide result; callers truncate to their data width.
  function automatic logic [63:0] ram_reset_value(
    input int          mode,
    input logic [63:0] seq_start,
    input logic [63:0] addr
  );
    ram_reset_value = (mode == RAM_RESET_SEQ) ? (seq_start + addr) : 64'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_partition_bank.sv
// ==========================================================================
// ram_partition_bank : one partition's storage, N write / M read ports
// Revision           : 1.0
// ==========================================================================
`default_nettype none

module ram_partition_bank
  import ram_cfg_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int ROW_W        = 5,
  parameter int WIDTH        = 32,
  parameter int NUM_WR_PORTS = 4,
  parameter int NUM_RD_PORTS = 4
) (
  input  logic                                      clk,
  input  logic [NUM_WR_PORTS-1:0]                   wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][ROW_W-1:0]        wr_row_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]        wr_data_i,
  input  logic                                      init_en_i,
  input  logic [ROW_W-1:0]                          init_row_i,
  input  logic [WIDTH-1:0]                          init_data_i,
  input  logic [NUM_RD_PORTS-1:0][ROW_W-1:0]        rd_row_i,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]        rd_data_o
);

  logic [WIDTH-1:0] mem_q [ROWS];

  // Later assignments win: highest-numbered port, then the init sweep.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (wr_en_i[k]) begin
        mem_q[wr_row_i[k]] <= wr_data_i[k];
      end
    end
    if (init_en_i) begin
      mem_q[init_row_i] <= init_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      rd_data_o[j] = mem_q[rd_row_i[j]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiport_ram_partitioned.sv
// ==========================================================================
// multiport_ram_partitioned : gated multi-port RAM with reset sweep FSM
// Revision                  : 1.0
// ==========================================================================
`default_nettype none

module multiport_ram_partitioned
  import ram_cfg_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter int INDEX         = 7,
  parameter int WIDTH         = 32,
  parameter int NUM_WR_PORTS  = 4,
  parameter int NUM_RD_PORTS  = 4,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int RESET_MODE    = 0,
  parameter int SEQ_START     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_WR_PORTS-1:0]              writePortGated_i,
  input  logic [NUM_RD_PORTS-1:0]              readPortGated_i,
  input  logic [NUM_PARTS-1:0]                 partitionGated_i,
  input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]   addr_i,
  output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]   data_o,
  input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]   addrWr_i,
  input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]   dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]              wrEn_i,
  output logic                                 ramReady_o
);

  localparam int ROWS  = DEPTH / NUM_PARTS;
  localparam int ROW_W = INDEX - NUM_PARTS_LOG;

  function automatic logic [NUM_PARTS_LOG-1:0] part_of(input logic [INDEX-1:0] a);
    return a[INDEX-1 -: NUM_PARTS_LOG];
  endfunction

  ram_state_t           state_q, state_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [NUM_PARTS-1:0] part_gated_q, part_gated_d;
  logic                 part_fall;
  logic                 init_en;

  logic [NUM_WR_PORTS-1:0][ROW_W-1:0]            wr_row;
  logic [NUM_RD_PORTS-1:0][ROW_W-1:0]            rd_row;
  logic [NUM_PARTS-1:0][NUM_WR_PORTS-1:0]        bank_wr_en;
  logic [NUM_PARTS-1:0][NUM_RD_PORTS-1:0][WIDTH-1:0] bank_rd;

  assign ramReady_o = (state_q == RAM_READY);
  assign part_fall  = |(part_gated_q & ~partitionGated_i);
  assign init_en    = (state_q == RAM_INIT) & ~reset;

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    part_gated_d = partitionGated_i;
    case (state_q)
      RAM_INIT: begin
        if (row_cnt_q == ROW_W'(ROWS - 1)) begin
          state_d   = RAM_READY;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      RAM_READY: begin
        // A partition coming back up has undefined contents: resweep.
        if (part_fall) state_d = RAM_INIT;
      end
      default: state_d = RAM_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RAM_INIT;
      row_cnt_q    <= '0;
      part_gated_q <= partitionGated_i;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      part_gated_q <= part_gated_d;
    end
  end

  always_comb begin
    wr_row     = '0;
    rd_row     = '0;
    bank_wr_en = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      wr_row[k] = addrWr_i[k][ROW_W-1:0];
      if (wrEn_i[k] && !writePortGated_i[k] && !partitionGated_i[part_of(addrWr_i[k])]
          && ramReady_o && !reset) begin
        bank_wr_en[part_of(addrWr_i[k])][k] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      rd_row[j] = addr_i[j][ROW_W-1:0];
    end
  end

  always_comb begin
    data_o = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      if (ramReady_o && !readPortGated_i[j] && !partitionGated_i[part_of(addr_i[j])]) begin
        data_o[j] = bank_rd[part_of(addr_i[j])][j];
      end
    end
  end

  for (genvar p = 0; p < NUM_PARTS; p++) begin : g_bank
    logic [WIDTH-1:0] init_data;
    assign init_data = WIDTH'(ram_reset_value(RESET_MODE, 64'(SEQ_START),
                                              64'(p * ROWS) + 64'(row_cnt_q)));

    ram_partition_bank #(
      .ROWS         (ROWS),
      .ROW_W        (ROW_W),
      .WIDTH        (WIDTH),
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .NUM_RD_PORTS (NUM_RD_PORTS)
    ) u_bank (
      .clk         (clk),
      .wr_en_i     (bank_wr_en[p]),
      .wr_row_i    (wr_row),
      .wr_data_i   (dataWr_i),
      .init_en_i   (init_en & ~partitionGated_i[p]),
      .init_row_i  (row_cnt_q),
      .init_data_i (init_data),
      .rd_row_i    (rd_row),
      .rd_data_o   (bank_rd[p])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multiport_ram_partitioned.sv
// ==========================================================================
// tb_multiport_ram_partitioned : scoreboard bench, zero and sequential modes
// Revision                     : 1.0
// ==========================================================================
`default_nettype none

module tb_multiport_ram_partitioned;

  localparam int W   = 32;
  localparam int IDX = 7;
  localparam int NW  = 4;
  localparam int NR  = 4;
  localparam int NP  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [NW-1:0]            wpg;
  logic [NR-1:0]            rpg;
  logic [NP-1:0]            pg;
  logic [NR-1:0][IDX-1:0]   addr;
  logic [NW-1:0][IDX-1:0]   waddr;
  logic [NW-1:0][W-1:0]     wdata;
  logic [NW-1:0]            wen;
  logic [NR-1:0][W-1:0]     dz, ds;
  logic                     rz, rs;

  // dut_z: zero reset; dut_s: sequential reset from 5. Inputs are shared.
  multiport_ram_partitioned #(.RESET_MODE(0), .SEQ_START(0)) dut_z (
    .clk(clk), .reset(reset), .writePortGated_i(wpg), .readPortGated_i(rpg),
    .partitionGated_i(pg), .addr_i(addr), .data_o(dz), .addrWr_i(waddr),
    .dataWr_i(wdata), .wrEn_i(wen), .ramReady_o(rz));

  multiport_ram_partitioned #(.RESET_MODE(1), .SEQ_START(5)) dut_s (
    .clk(clk), .reset(reset), .writePortGated_i(wpg), .readPortGated_i(rpg),
    .partitionGated_i(pg), .addr_i(addr), .data_o(ds), .addrWr_i(waddr),
    .dataWr_i(wdata), .wrEn_i(wen), .ramReady_o(rs));

  typedef struct {
    int         cyc;
    bit         sel;
    int         port;
    logic [W-1:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_data(input bit sel, input int port, input logic [W-1:0] e, input string n);
    exp_t x;
    x.cyc = cyc; x.sel = sel; x.port = port; x.exp = e; x.name = n;
    sb.push_back(x);
  endtask

  task automatic exp_both(input int port, input logic [W-1:0] ez, input logic [W-1:0] es,
                          input string n);
    exp_data(1'b0, port, ez, n);
    exp_data(1'b1, port, es, n);
  endtask

  task automatic exp_rdy(input bit e, input string n);
    exp_data(1'b0, -1, {31'd0, e}, n);
    exp_data(1'b1, -1, {31'd0, e}, n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  exp_t         mx;
  logic [W-1:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mx = sb.pop_front();
      if (mx.port < 0) act = mx.sel ? {31'd0, rs} : {31'd0, rz};
      else             act = mx.sel ? ds[mx.port] : dz[mx.port];
      checks++;
      if (mx.cyc != cyc || act !== mx.exp) begin
        failures++;
        $display("FAIL %s dut=%0d port=%0d cyc=%0d actual=%h required=%h",
                 mx.name, mx.sel, mx.port, cyc, act, mx.exp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wpg = '0; rpg = '0; pg = '0;
    addr = '0; waddr = '0; wdata = '0; wen = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      exp_rdy(1'b0, "reset_ready");
      exp_both(0, 0, 0, "reset_data");
    end

    step();
    reset = 1'b0;
    addr[0] = 7'd33;
    exp_rdy(1'b0, "release_ready");

    for (int k = 1; k <= 32; k++) begin
      step();
      exp_rdy(k == 32, "init_ready");
      if (k == 16) exp_data(1'b1, 0, 0, "init_read_masked");
      if (k == 32) exp_data(1'b1, 0, 38, "first_ready_read");
    end

    step();
    addr[0] = 7'd0; addr[1] = 7'd33; addr[2] = 7'd127; addr[3] = 7'd64;
    exp_both(0, 0, 5,   "reset_val_0");
    exp_both(1, 0, 38,  "reset_val_33");
    exp_both(2, 0, 132, "reset_val_127");
    exp_both(3, 0, 69,  "reset_val_64");

    step();
    wen = 4'b1001;
    waddr[0] = 7'd10; wdata[0] = 32'hAAAA;
    waddr[3] = 7'd10; wdata[3] = 32'hBBBB;
    addr[0] = 7'd10;
    exp_both(0, 0, 15, "same_cycle_old");

    step();
    wen = '0;
    exp_both(0, 32'hBBBB, 32'hBBBB, "priority_port3");

    step();
    pg = 4'b0100;
    wen[0] = 1'b1; waddr[0] = 7'd70; wdata[0] = 32'h1234;
    addr[0] = 7'd70; addr[1] = 7'd10;
    exp_both(0, 0, 0, "gated_part_read");
    exp_both(1, 32'hBBBB, 32'hBBBB, "ungated_part_read");
    exp_rdy(1'b1, "gated_still_ready");

    step();
    wen = '0;
    exp_both(0, 0, 0, "gated_part_after_write");

    step();
    pg = '0;
    exp_rdy(1'b1, "ungate_same_cycle");

    for (int k = 1; k <= 33; k++) begin
      step();
      exp_rdy(k == 33, "reinit_ready");
    end

    step();
    addr[0] = 7'd10; addr[1] = 7'd70;
    exp_both(0, 0, 15, "reinit_rewrote_10");
    exp_both(1, 0, 75, "reinit_rewrote_70");

    step();
    wpg = 4'b0010; rpg = 4'b0100;
    wen = 4'b0011;
    waddr[0] = 7'd20; wdata[0] = 32'h5555;
    waddr[1] = 7'd4;  wdata[1] = 32'hDEAD;

    step();
    wen = '0;
    addr[0] = 7'd4; addr[1] = 7'd20; addr[2] = 7'd20;
    exp_both(0, 0, 9, "wr_port_gated");
    exp_both(1, 32'h5555, 32'h5555, "wr_port_ok");
    exp_both(2, 0, 0, "rd_port_gated");

    step();
    rpg = '0;
    wpg = '0;
    exp_both(2, 32'h5555, 32'h5555, "rd_port_ungated");

    step();
    reset = 1'b1;

    step();
    reset = 1'b0;
    exp_rdy(1'b0, "reset_from_ready");

    for (int k = 1; k <= 15; k++) begin
      step();
      exp_rdy(1'b0, "sweep_before_reset");
      if (k == 15) reset = 1'b1;
    end

    step();
    reset = 1'b0;
    exp_rdy(1'b0, "midsweep_release");

    for (int k = 1; k <= 32; k++) begin
      step();
      exp_rdy(k == 32, "restart_ready");
      if (k == 25) begin
        wen[0] = 1'b1; waddr[0] = 7'd20; wdata[0] = 32'h7777;
      end
      if (k == 26) wen = '0;
    end

    step();
    addr[0] = 7'd20;
    exp_both(0, 0, 25, "init_write_ignored");

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiport_ram_partitioned.md
Name: multiport_ram_partitioned

Overview:
- Parametrised multi-write, multi-read register-file RAM that succeeds the fixed-width active-list data RAM.
- Read, write and partition counts are generic, so the Active List, RMT and similar dispatch/commit structures can share one block.
- Adds per-lane and per-partition power gating.
- Adds a hardware reset sweep state machine, which initialises storage one row per partition per cycle, and a ready handshake.
- Sits between dispatch (write ports) and commit/retire (read ports).

Parameters:
- DEPTH, 128, total entries.
- INDEX, 7, address width (log2 DEPTH).
- WIDTH, 32, data bits per entry.
- NUM_WR_PORTS, 4, write ports (dispatch lanes).
- NUM_RD_PORTS, 4, read ports (commit lanes).
- NUM_PARTS, 4, equal partitions (power-gating granules). DEPTH must be divisible by NUM_PARTS.
- NUM_PARTS_LOG, 2, log2 NUM_PARTS. Must be ≥1, i.e. NUM_PARTS ≥ 2.
- RESET_MODE, 0, 0 = reset every entry to 0; 1 = reset entry a to (SEQ_START + a) truncated to WIDTH.
- SEQ_START, 0, base value for sequential reset mode.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- writePortGated_i  in  NUM_WR_PORTS  1 = write lane powered off
- readPortGated_i  in  NUM_RD_PORTS  1 = read lane powered off
- partitionGated_i  in  NUM_PARTS  1 = partition powered off
- addr_i  in  NUM_RD_PORTS x INDEX  read addresses
- data_o  out  NUM_RD_PORTS x WIDTH  read data
- addrWr_i  in  NUM_WR_PORTS x INDEX  write addresses
- dataWr_i  in  NUM_WR_PORTS x WIDTH  write data
- wrEn_i  in  NUM_WR_PORTS  write enables
- ramReady_o  out  1  storage initialised; writes accepted

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Address map:
  - partition = addr[INDEX-1 -: NUM_PARTS_LOG].
  - row = addr[INDEX-NUM_PARTS_LOG-1:0].
  - ROWS = DEPTH/NUM_PARTS.
- States: INIT and READY.
- Reset:
  - While reset=1: state<=INIT, rowCnt<=0, ramReady_o=0, no storage writes.
  - Every output is 0 during and after reset until READY.
- INIT sweep:
  - Each cycle, writes the reset value to row rowCnt in every non-gated partition in parallel. For partition p the value is 0, or SEQ_START + (p*ROWS + rowCnt) in mode 1.
  - Gated partitions are skipped.
  - rowCnt increments each cycle. On rowCnt==ROWS-1 the block goes to READY and rowCnt<=0.
  - ramReady_o is registered: it rises exactly ROWS cycles after the first cycle with reset=0.
  - External writes are ignored in INIT.
- Re-initialisation:
  - In READY, if any partitionGated_i bit falls (1->0, registered edge detect), the block returns to INIT next cycle.
  - ramReady_o drops and a full sweep reruns; only non-gated partitions are written.
  - A reset mid-sweep restarts from rowCnt=0.
- Writes (READY only):
  - Port k writes when wrEn_i[k] & ~writePortGated_i[k] & ~partitionGated_i[partition(addrWr_i[k])].
  - The write commits on the clock edge; the new data is visible to reads the following cycle.
  - If several writes to the same address are enabled in one cycle, the highest-numbered port wins.
- Reads:
  - Combinational from storage; no bypass.
  - A read and write to the same address in the same cycle returns the old data.
  - data_o[j] = 0 if readPortGated_i[j], if the target partition is gated, or if not READY.
- Gating:
  - A gated partition's contents are undefined after gating. Reads of it return 0 regardless of contents.
  - Contents become valid again only after the re-init sweep.

Decomposition:
- Package ram_cfg_pkg holds:
  - localparams RAM_RESET_ZERO=0 and RAM_RESET_SEQ=1;
  - typedef enum {RAM_INIT, RAM_READY} ram_state_t;
  - helper function ram_reset_value(mode, seqStart, addr).
- Sub-module ram_partition_bank holds one partition's ROWS x WIDTH storage:
  - NUM_WR_PORTS row-addressed write ports with per-port enable and highest-index priority;
  - an init write port that overrides the other ports;
  - NUM_RD_PORTS combinational read ports.
- The top level instantiates NUM_PARTS banks plus the FSM, address decode and output muxing.

Test Plan:
- Defaults, RESET_MODE=0: hold reset 3 cycles, release -> ramReady_o=0 for cycles 1..31, =1 at cycle 32; every read afterwards returns 0.
- RESET_MODE=1, SEQ_START=5: after ready, read addresses 0, 33, 127 -> 5, 38, 132.
- Same-cycle writes from port 0 (addr 10, 0xAAAA) and port 3 (addr 10, 0xBBBB) -> the same-cycle read returns the old value; the next-cycle read of 10 returns 0xBBBB.
- Gate partition 2, write to addr 70 -> no write; read of 70 returns 0.
- Ungate partition 2 -> ramReady_o falls next cycle and rises 32 cycles later.
- Gate write port 1 and read port 2:
  - a write via port 1 to addr 4 is dropped (read of 4 still returns 0);
  - data_o[2] = 0 while reading a written address on port 2.
- Assert reset at sweep cycle 15 -> ramReady_o stays 0; the sweep restarts and ready rises 32 cycles after reset release.
